// File: rtl/io_pkg.sv
// Shared types and constants for the dev_io CPU-side controller.
package io_pkg;

  // Controller states; IDLE is the reset state.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    G_WAIT = 3'd1,
    G_POP  = 3'd2,
    G_GAP  = 3'd3,
    P_PUSH = 3'd4,
    P_WAIT = 3'd5,
    P_LF   = 3'd6,
    DONE   = 3'd7
  } io_ctrl_state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Input-side newline mapping: CR becomes LF when translation is enabled.
  function automatic logic [7:0] map_rx(input logic [7:0] c, input logic xlate);
    if (xlate && (c == ASCII_CR)) begin
      return ASCII_LF;
    end else begin
      return c;
    end
  endfunction

endpackage

// File: rtl/io_ctrl.sv
// CPU-side controller for dev_io: turns single-cycle getc/putc requests into
// the dev_io pop/push handshakes, stalls the core via busy, and optionally
// translates newlines (LF->CRLF on output, CR->LF on input).
module io_ctrl
  import io_pkg::*;
#(
  parameter bit CRLF_XLATE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_getc,
  input  logic       req_putc,
  input  logic [7:0] req_char,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_char,
  input  logic       getc_en,
  output logic       getc_pop,
  input  logic [7:0] getc_char,
  output logic       putc_push,
  input  logic       putc_push_done,
  output logic [7:0] putc_char
);

  io_ctrl_state_t state_r, state_s;
  logic       pending_lf_r, pending_lf_s;
  logic       busy_r, busy_s;
  logic       done_r, done_s;
  logic       getc_pop_r, getc_pop_s;
  logic       putc_push_r, putc_push_s;
  logic [7:0] rd_char_r, rd_char_s;
  logic [7:0] putc_char_r, putc_char_s;

  // Next-state and next-output computation; every output is registered below.
  always_comb begin
    state_s      = state_r;
    pending_lf_s = pending_lf_r;
    busy_s       = busy_r;
    done_s       = 1'b0;
    getc_pop_s   = 1'b0;
    putc_push_s  = putc_push_r;
    rd_char_s    = rd_char_r;
    putc_char_s  = putc_char_r;
    case (state_r)
      IDLE: begin
        if (req_putc) begin
          // putc wins over getc when both arrive together
          busy_s = 1'b1;
          if (CRLF_XLATE && (req_char == ASCII_LF)) begin
            putc_char_s  = ASCII_CR;
            pending_lf_s = 1'b1;
          end else begin
            putc_char_s  = req_char;
            pending_lf_s = 1'b0;
          end
          state_s = P_PUSH;
        end else if (req_getc) begin
          busy_s  = 1'b1;
          state_s = G_WAIT;
        end else begin
          state_s = IDLE;
        end
      end
      P_PUSH: begin
        putc_push_s = 1'b1;
        state_s     = P_WAIT;
      end
      P_WAIT: begin
        // push stays up (with stable data) until dev_io acknowledges once
        if (putc_push_done) begin
          putc_push_s = 1'b0;
          if (pending_lf_r) begin
            state_s = P_LF;
          end else begin
            state_s = DONE;
          end
        end else begin
          state_s = P_WAIT;
        end
      end
      P_LF: begin
        pending_lf_s = 1'b0;
        putc_char_s  = ASCII_LF;
        state_s      = P_PUSH;
      end
      G_WAIT: begin
        // no timeout: the core is stalled until input arrives
        if (getc_en) begin
          getc_pop_s = 1'b1;
          rd_char_s  = map_rx(getc_char, CRLF_XLATE);
          state_s    = G_POP;
        end else begin
          state_s = G_WAIT;
        end
      end
      G_POP: begin
        state_s = G_GAP;
      end
      G_GAP: begin
        // settle cycle so the FIFO is never popped on consecutive cycles
        state_s = DONE;
      end
      DONE: begin
        done_s  = 1'b1;
        busy_s  = 1'b0;
        state_s = IDLE;
      end
      default: begin
        busy_s      = 1'b0;
        putc_push_s = 1'b0;
        state_s     = IDLE;
      end
    endcase
  end

  // State, pending-LF flag and all output registers, async active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      pending_lf_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      getc_pop_r   <= 1'b0;
      putc_push_r  <= 1'b0;
      rd_char_r    <= 8'h00;
      putc_char_r  <= 8'h00;
    end else begin
      state_r      <= state_s;
      pending_lf_r <= pending_lf_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      getc_pop_r   <= getc_pop_s;
      putc_push_r  <= putc_push_s;
      rd_char_r    <= rd_char_s;
      putc_char_r  <= putc_char_s;
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign getc_pop  = getc_pop_r;
  assign putc_push = putc_push_r;
  assign rd_char   = rd_char_r;
  assign putc_char = putc_char_r;

endmodule
